io_client: RTL and testbench

- Client/initiator end of the if_io interface; the counterpart to the UART-backed I/O server that owns the in/out FIFOs.
- Sits between the ULM CPU execute stage and the server.
- Turns single CPU I/O requests into if_io handshakes:
  - blocking getc
  - non-blocking getc
  - putc
- Returns one response per request and keeps a sticky input-overrun flag.

---
 rtl/io_pkg.sv | 19 +
 rtl/if_io.sv | 20 ++
 rtl/io_client.sv | 124 ++++++++++++
 tb/tb_io_client.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared types for the if_io client: CPU I/O opcodes and the client FSM encoding.
package io_pkg;

  typedef enum logic [1:0] {
    IO_OP_GETC    = 2'd0,
    IO_OP_GETC_NB = 2'd1,
    IO_OP_PUTC    = 2'd2
  } io_op_t;

  typedef logic [2:0] io_client_state_t;

  localparam io_client_state_t ST_IDLE      = 3'd0;
  localparam io_client_state_t ST_GETC_WAIT = 3'd1;
  localparam io_client_state_t ST_GETC_POP  = 3'd2;
  localparam io_client_state_t ST_GETC_GAP  = 3'd3;
  localparam io_client_state_t ST_PUTC_PUSH = 3'd4;
  localparam io_client_state_t ST_RESP      = 3'd5;

endpackage

// File: rtl/if_io.sv
// Handshake bundle between the I/O client and the UART-backed I/O server.
interface if_io;
  logic       getc_en;
  logic [7:0] getc_char;
  logic       getc_pop;
  logic       putc_push;
  logic [7:0] putc_char;
  logic       putc_push_done;
  logic       inbuf_full;

  modport client (
    input  getc_en, getc_char, putc_push_done, inbuf_full,
    output getc_pop, putc_push, putc_char
  );

  modport server (
    output getc_en, getc_char, putc_push_done, inbuf_full,
    input  getc_pop, putc_push, putc_char
  );
endinterface

// File: rtl/io_client.sv
// CPU-side I/O client: converts single getc/getc_nb/putc requests into if_io
// handshakes, one response per request, plus a sticky input-overrun flag.
module io_client
  import io_pkg::*;
#(
  parameter logic [7:0] GETC_NB_EMPTY_CHAR = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_op,
  input  logic [7:0] req_char,
  output logic       req_ready,
  output logic       rsp_valid,
  output logic [7:0] rsp_char,
  output logic       rsp_empty,
  input  logic       ovr_clr,
  output logic       rx_overrun,
  if_io.client       io
);

  io_client_state_t state_r;
  io_op_t           op_r;

  // Request FSM; every output toggles on the transition into the state that owns it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      op_r         <= IO_OP_GETC;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_char     <= 8'h00;
      rsp_empty    <= 1'b0;
      io.getc_pop  <= 1'b0;
      io.putc_push <= 1'b0;
      io.putc_char <= 8'h00;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            rsp_char  <= 8'h00;
            rsp_empty <= 1'b0;
            case (req_op)
              IO_OP_GETC, IO_OP_GETC_NB: begin
                op_r    <= io_op_t'(req_op);
                state_r <= ST_GETC_WAIT;
              end
              IO_OP_PUTC: begin
                io.putc_char <= req_char;
                io.putc_push <= 1'b1;
                state_r      <= ST_PUTC_PUSH;
              end
              default: begin
                rsp_valid <= 1'b1;
                state_r   <= ST_RESP;
              end
            endcase
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_GETC_WAIT: begin
          if (io.getc_en) begin
            rsp_char    <= io.getc_char;
            io.getc_pop <= 1'b1;
            state_r     <= ST_GETC_POP;
          end else if (op_r == IO_OP_GETC_NB) begin
            rsp_char  <= GETC_NB_EMPTY_CHAR;
            rsp_empty <= 1'b1;
            rsp_valid <= 1'b1;
            state_r   <= ST_RESP;
          end else begin
            state_r <= ST_GETC_WAIT;
          end
        end
        ST_GETC_POP: begin
          io.getc_pop <= 1'b0;
          state_r     <= ST_GETC_GAP;
        end
        // The server's getc_en is stale here, so it is deliberately not sampled.
        ST_GETC_GAP: begin
          rsp_valid <= 1'b1;
          state_r   <= ST_RESP;
        end
        ST_PUTC_PUSH: begin
          if (io.putc_push_done) begin
            io.putc_push <= 1'b0;
            rsp_valid    <= 1'b1;
            state_r      <= ST_RESP;
          end else begin
            state_r <= ST_PUTC_PUSH;
          end
        end
        ST_RESP: begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state_r   <= ST_IDLE;
        end
        default: begin
          rsp_valid    <= 1'b0;
          req_ready    <= 1'b1;
          io.getc_pop  <= 1'b0;
          io.putc_push <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  // Sticky overrun flag; a full input buffer outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_overrun <= 1'b0;
    end else if (io.inbuf_full) begin
      rx_overrun <= 1'b1;
    end else if (ovr_clr) begin
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= rx_overrun;
    end
  end

endmodule

// File: tb/tb_io_client.sv
// Directed bench for io_client against a small behavioural I/O server
// (4-entry input FIFO fed by a UART stand-in, programmable putc done delay).
module tb_io_client;
  import io_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req_valid = 1'b0;
  logic [1:0] req_op = 2'd0;
  logic [7:0] req_char = 8'h00;
  logic       ovr_clr = 1'b0;
  logic       req_ready, rsp_valid, rsp_empty, rx_overrun;
  logic [7:0] rsp_char;

  if_io io_bus ();

  io_client #(.GETC_NB_EMPTY_CHAR(8'h00)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op),
    .req_char(req_char), .req_ready(req_ready), .rsp_valid(rsp_valid),
    .rsp_char(rsp_char), .rsp_empty(rsp_empty), .ovr_clr(ovr_clr),
    .rx_overrun(rx_overrun), .io(io_bus)
  );

  always #5 clk = ~clk;

  // Server model state
  logic       uart_push = 1'b0;
  logic [7:0] uart_char = 8'h00;
  logic [7:0] fmem [4];
  logic [1:0] rdp = 2'd0, wrp = 2'd0;
  logic [2:0] cnt = 3'd0;
  logic       srv_en = 1'b0, srv_full = 1'b0, srv_done = 1'b0;
  logic [7:0] srv_char = 8'h00;
  int         pcnt = 0, done_dly = 3;
  int         push_cnt = 0;
  logic [7:0] last_push_char = 8'h00;
  int         pop_cnt = 0, cyc = 0, last_pop_cyc = 0, min_pop_gap = 1000;
  logic       pop_prev = 1'b0, wide_pop = 1'b0;

  assign io_bus.getc_en        = srv_en;
  assign io_bus.getc_char      = srv_char;
  assign io_bus.inbuf_full     = srv_full;
  assign io_bus.putc_push_done = srv_done;

  always @(posedge clk) begin
    if (io_bus.getc_pop && cnt != 3'd0) rdp <= rdp + 2'd1;
    if (uart_push && cnt != 3'd4) begin
      fmem[wrp] <= uart_char;
      wrp <= wrp + 2'd1;
    end
    cnt <= cnt + ((uart_push && cnt != 3'd4) ? 3'd1 : 3'd0)
               - ((io_bus.getc_pop && cnt != 3'd0) ? 3'd1 : 3'd0);
    srv_en   <= (cnt != 3'd0);
    srv_char <= fmem[rdp];
    srv_full <= (cnt == 3'd4);
    if (io_bus.putc_push && !srv_done) begin
      if (pcnt == done_dly - 1) begin
        srv_done       <= 1'b1;
        push_cnt       <= push_cnt + 1;
        last_push_char <= io_bus.putc_char;
        pcnt           <= 0;
      end else begin
        pcnt <= pcnt + 1;
      end
    end else begin
      srv_done <= 1'b0;
      pcnt     <= 0;
    end
    if (io_bus.getc_pop) begin
      pop_cnt <= pop_cnt + 1;
      if (pop_prev) wide_pop <= 1'b1;
      if (pop_cnt != 0 && (cyc - last_pop_cyc) < min_pop_gap) min_pop_gap <= cyc - last_pop_cyc;
      last_pop_cyc <= cyc;
    end
    pop_prev <= io_bus.getc_pop;
    cyc <= cyc + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] ch);
    req_valid = 1'b1;
    req_op    = op;
    req_char  = ch;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Returns cycles from the accept cycle to the rsp_valid cycle.
  task automatic wait_rsp(input int maxc, output int lat);
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < maxc) begin
      @(negedge clk);
      lat++;
    end
    check("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
  endtask

  task automatic uart_send(input logic [7:0] ch);
    uart_push = 1'b1;
    uart_char = ch;
    @(negedge clk);
    uart_push = 1'b0;
  endtask

  initial begin
    int lat;
    int saved;
    int seen;

    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_char", {24'd0, rsp_char}, 32'd0);
    check("rst_rsp_empty", {31'd0, rsp_empty}, 32'd0);
    check("rst_overrun", {31'd0, rx_overrun}, 32'd0);
    check("rst_pop", {31'd0, io_bus.getc_pop}, 32'd0);
    check("rst_push", {31'd0, io_bus.putc_push}, 32'd0);
    check("rst_putc_char", {24'd0, io_bus.putc_char}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // PUTC 'A' with done after 3 push cycles
    done_dly = 3;
    issue(IO_OP_PUTC, 8'h41);
    check("putc_push_hi", {31'd0, io_bus.putc_push}, 32'd1);
    check("putc_char", {24'd0, io_bus.putc_char}, 32'h41);
    wait_rsp(20, lat);
    check("putc_lat", lat, 32'd5);
    check("putc_push_lo", {31'd0, io_bus.putc_push}, 32'd0);
    check("putc_rsp_empty", {31'd0, rsp_empty}, 32'd0);
    check("putc_rsp_char", {24'd0, rsp_char}, 32'd0);
    check("putc_push_cnt", push_cnt, 32'd1);
    check("putc_out_char", {24'd0, last_push_char}, 32'h41);
    @(negedge clk);
    check("putc_rsp_pulse", {31'd0, rsp_valid}, 32'd0);

    // Preload "xy", two GETCs back-to-back
    uart_send(8'h78);
    uart_send(8'h79);
    @(negedge clk);
    @(negedge clk);
    check("getc1_ready", {31'd0, req_ready}, 32'd1);
    issue(IO_OP_GETC, 8'h00);
    wait_rsp(20, lat);
    check("getc1_lat", lat, 32'd4);
    check("getc1_char", {24'd0, rsp_char}, 32'h78);
    check("getc1_empty", {31'd0, rsp_empty}, 32'd0);
    @(negedge clk);
    issue(IO_OP_GETC, 8'h00);
    wait_rsp(20, lat);
    check("getc2_lat", lat, 32'd4);
    check("getc2_char", {24'd0, rsp_char}, 32'h79);
    check("getc_pop_cnt", pop_cnt, 32'd2);
    check("getc_pop_wide", {31'd0, wide_pop}, 32'd0);
    check("getc_pop_gap", {31'd0, (min_pop_gap >= 3)}, 32'd1);
    @(negedge clk);
    @(negedge clk);

    // GETC_NB on empty input
    saved = pop_cnt;
    issue(IO_OP_GETC_NB, 8'h00);
    wait_rsp(20, lat);
    check("nb_lat", lat, 32'd2);
    check("nb_empty", {31'd0, rsp_empty}, 32'd1);
    check("nb_char", {24'd0, rsp_char}, 32'd0);
    check("nb_no_pop", pop_cnt, saved);
    @(negedge clk);

    // Illegal opcode answers next cycle with zeros
    issue(2'b11, 8'h00);
    wait_rsp(20, lat);
    check("ill_lat", lat, 32'd1);
    check("ill_char", {24'd0, rsp_char}, 32'd0);
    check("ill_empty", {31'd0, rsp_empty}, 32'd0);
    @(negedge clk);

    // Blocking GETC waits on empty input; a stray request meanwhile is ignored
    saved = push_cnt;
    issue(IO_OP_GETC, 8'h00);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (i == 50) begin
        req_valid = 1'b1;
        req_op    = IO_OP_PUTC;
        req_char  = 8'h33;
      end
      if (i == 51) req_valid = 1'b0;
      if (rsp_valid === 1'b1) seen++;
      @(negedge clk);
    end
    check("blk_no_rsp", seen, 32'd0);
    check("blk_no_push", push_cnt, saved);
    uart_send(8'h5A);
    wait_rsp(20, lat);
    check("blk_char", {24'd0, rsp_char}, 32'h5A);
    check("blk_empty", {31'd0, rsp_empty}, 32'd0);
    @(negedge clk);

    // Overrun: fill, clear while full, drain, clear
    uart_send(8'h61);
    uart_send(8'h62);
    uart_send(8'h63);
    check("ovr_not_full", {31'd0, rx_overrun}, 32'd0);
    uart_send(8'h64);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("ovr_set", {31'd0, rx_overrun}, 32'd1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr_clr_while_full", {31'd0, rx_overrun}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      issue(IO_OP_GETC, 8'h00);
      wait_rsp(20, lat);
      check("drain_char", {24'd0, rsp_char}, 32'h61 + k);
      @(negedge clk);
    end
    @(negedge clk);
    @(negedge clk);
    check("ovr_sticky", {31'd0, rx_overrun}, 32'd1);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    check("ovr_cleared", {31'd0, rx_overrun}, 32'd0);

    // Reset during PUTC_PUSH abandons the request
    done_dly = 10;
    saved = push_cnt;
    issue(IO_OP_PUTC, 8'h42);
    @(negedge clk);
    check("rstmid_pushing", {31'd0, io_bus.putc_push}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("rstmid_push", {31'd0, io_bus.putc_push}, 32'd0);
    check("rstmid_putc_char", {24'd0, io_bus.putc_char}, 32'd0);
    check("rstmid_ready", {31'd0, req_ready}, 32'd1);
    check("rstmid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (rsp_valid === 1'b1) seen++;
      @(negedge clk);
    end
    check("rstmid_no_rsp", seen, 32'd0);
    check("rstmid_no_push", push_cnt, saved);

    // Recovery: PUTC with done in the first push cycle
    done_dly = 1;
    issue(IO_OP_PUTC, 8'h43);
    wait_rsp(20, lat);
    check("rec_lat", lat, 32'd3);
    check("rec_push_cnt", push_cnt, saved + 1);
    check("rec_out_char", {24'd0, last_push_char}, 32'h43);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
